// File: rtl/windowed_sequence_adder.sv
// windowed_sequence_adder: streaming moving-window adder.
// Outputs the sum of the most recent 2^W accepted samples, with W chosen at
// run time from 0..N (values above N clamp to N). One-cycle latency, one
// sample per cycle, synchronous clear, warm-up/full indication.
// Optional feature: define WSUM_AVG_EN to add the registered mean output avg.
module windowed_sequence_adder #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int LW = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DW-1:0]     inp,
    input  logic [LW-1:0]     win_sel,
    input  logic              clear,
    output logic [DW+N-1:0]   outp,
    output logic              out_valid,
    output logic              out_full
`ifdef WSUM_AVG_EN
    ,
    output logic [DW-1:0]     avg
`endif
);

    localparam int SW    = DW + N;
    localparam int DEPTH = 1 << N;
    localparam logic [LW-1:0] WMAX = LW'(N);

    logic [DW-1:0] mem [DEPTH];
    logic [N-1:0]  wp, wp_d;
    logic [N:0]    cnt, cnt_d;
    logic [LW-1:0] win_q, w_clamp;
    logic [SW-1:0] acc, acc_d;
    logic [SW-1:0] outp_d;
    logic          ov_d, of_d, wr_en;

    logic [N:0]    span;
    logic [N-1:0]  rd_addr;
    logic [DW-1:0] old;
    logic [SW-1:0] acc_sum;
    logic [N:0]    cnt_inc;

    // Window span and oldest-sample lookup; the read happens before this
    // cycle's write, so at W==N (read slot == write slot) it sees the old value.
    always_comb begin
        w_clamp = (win_sel > WMAX) ? WMAX : win_sel;
        span    = {{N{1'b0}}, 1'b1} << w_clamp;
        rd_addr = wp - span[N-1:0];
        old     = (cnt == span) ? mem[rd_addr] : '0;
        acc_sum = acc + SW'(inp) - SW'(old);
        cnt_inc = (cnt == span) ? cnt : cnt + 1'b1;
    end

    // Next-state selection: clear beats window change beats plain accept.
    always_comb begin
        acc_d  = acc;
        cnt_d  = cnt;
        wp_d   = wp;
        outp_d = outp;
        ov_d   = 1'b0;
        of_d   = out_full;
        wr_en  = 1'b0;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
            of_d  = 1'b0;
        end else if (w_clamp != win_q) begin
            // New window starts empty; a sample arriving now is its first.
            acc_d = '0;
            cnt_d = '0;
            of_d  = 1'b0;
            if (in_valid) begin
                acc_d  = SW'(inp);
                cnt_d  = {{N{1'b0}}, 1'b1};
                wr_en  = 1'b1;
                wp_d   = wp + 1'b1;
                outp_d = SW'(inp);
                ov_d   = 1'b1;
                of_d   = (span == {{N{1'b0}}, 1'b1});
            end
        end else if (in_valid) begin
            acc_d  = acc_sum;
            cnt_d  = cnt_inc;
            wr_en  = 1'b1;
            wp_d   = wp + 1'b1;
            outp_d = acc_sum;
            ov_d   = 1'b1;
            of_d   = (cnt_inc == span);
        end
    end

    // Sample storage; contents are never read before being written because
    // reads are gated by the fill counter, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wp] <= inp;
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp        <= '0;
            cnt       <= '0;
            win_q     <= WMAX;
            acc       <= '0;
            outp      <= '0;
            out_valid <= 1'b0;
            out_full  <= 1'b0;
        end else begin
            wp        <= wp_d;
            cnt       <= cnt_d;
            win_q     <= w_clamp;
            acc       <= acc_d;
            outp      <= outp_d;
            out_valid <= ov_d;
            out_full  <= of_d;
        end
    end

`ifdef WSUM_AVG_EN
    logic [SW-1:0] avg_full;

    // Mean of the window; meaningful only while out_full is set.
    always_comb begin
        avg_full = acc_d >> w_clamp;
    end

    // Mean register tracks outp: updates only on accepted samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   avg <= '0;
        else if (ov_d) avg <= avg_full[DW-1:0];
    end
`endif

endmodule

// File: tb/tb_windowed_sequence_adder.sv
// Bench for windowed_sequence_adder: queue-based window model checked every
// cycle, plus hand-computed literal expectations from directed vectors.
module tb_windowed_sequence_adder;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int LW = $clog2(N + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [DW-1:0]     inp;
    logic [LW-1:0]     win_sel;
    logic              clear;
    logic [DW+N-1:0]   outp;
    logic              out_valid;
    logic              out_full;
`ifdef WSUM_AVG_EN
    logic [DW-1:0]     avg;
`endif

    windowed_sequence_adder #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inp(inp),
        .win_sel(win_sel), .clear(clear), .outp(outp),
        .out_valid(out_valid), .out_full(out_full)
`ifdef WSUM_AVG_EN
        , .avg(avg)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int vcount = 0;

    // model state
    int q[$];
    int mw;
    int exp_outp, exp_valid, exp_full, exp_avg;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mw = N;
        exp_outp = 0; exp_valid = 0; exp_full = 0; exp_avg = 0;
    endtask

    task automatic model_update(input bit v, input int d, input int ws, input bit clr);
        int w, sum;
        w = (ws > N) ? N : ws;
        if (clr) begin
            q.delete();
            mw = w;
            exp_valid = 0;
            exp_full = 0;
            return;
        end
        if (w != mw) begin
            mw = w;
            q.delete();
            exp_full = 0;
        end
        if (v) begin
            q.push_back(d);
            while (q.size() > (1 << mw)) void'(q.pop_front());
            sum = 0;
            foreach (q[i]) sum += q[i];
            exp_outp  = sum;
            exp_valid = 1;
            exp_full  = (q.size() == (1 << mw));
            exp_avg   = sum >> mw;
        end else begin
            exp_valid = 0;
        end
    endtask

    task automatic compare();
        check("outp", int'(outp), exp_outp);
        check("out_valid", int'(out_valid), exp_valid);
        check("out_full", int'(out_full), exp_full);
`ifdef WSUM_AVG_EN
        check("avg", int'(avg), exp_avg);
`endif
        if (out_valid) vcount++;
    endtask

    task automatic step(input bit v, input int d, input int ws, input bit clr);
        in_valid = v;
        inp      = DW'(d);
        win_sel  = LW'(ws);
        clear    = clr;
        @(posedge clk);
        model_update(v, d, ws, clr);
        #1;
        compare();
    endtask

    initial begin
        int vstart;
        rst_n = 1'b0; in_valid = 1'b0; inp = '0; win_sel = LW'(N); clear = 1'b0;
        model_reset();
        #12;
        check("rst_outp", int'(outp), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_full", int'(out_full), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // warm-up and steady state, W=4, samples 1..20
        for (int k = 1; k <= 20; k++) begin
            step(1, k, 4, 0);
            if (k == 15) begin
                check("warm15_outp", int'(outp), 120);
                check("warm15_full", int'(out_full), 0);
            end
            if (k == 16) begin
                check("warm16_outp", int'(outp), 136);
                check("warm16_full", int'(out_full), 1);
            end
            if (k == 17) check("warm17_outp", int'(outp), 152);
            if (k == 20) check("warm20_outp", int'(outp), 200);
        end

        // max value, fresh window
        step(0, 0, 4, 1);
        for (int k = 1; k <= 17; k++) begin
            step(1, 255, 4, 0);
            if (k >= 16) check("max_outp", int'(outp), 4080);
        end
`ifdef WSUM_AVG_EN
        check("max_avg", int'(avg), 255);
`endif

        // small window with gaps
        vstart = vcount;
        for (int k = 1; k <= 5; k++) begin
            step(1, 10 * k, 2, 0);
            if (k == 2) check("gap2_outp", int'(outp), 30);
            if (k == 3) begin
                check("gap3_outp", int'(outp), 60);
                check("gap3_full", int'(out_full), 0);
            end
            if (k == 4) check("gap4_full", int'(out_full), 1);
            step(0, 0, 2, 0);
            step(0, 0, 2, 0);
        end
        check("gap_final_outp", int'(outp), 140);
        check("gap_pulses", vcount - vstart, 5);
`ifdef WSUM_AVG_EN
        check("gap_avg", int'(avg), 35);
`endif

        // window changes mid-stream
        step(1, 7, 0, 0);
        check("w0_outp", int'(outp), 7);
        check("w0_full", int'(out_full), 1);
        step(1, 8, 0, 0);
        check("w0b_outp", int'(outp), 8);
        step(1, 3, 5, 0);
        check("w5_outp", int'(outp), 3);
        check("w5_full", int'(out_full), 0);

        // clear discards the sample presented with it
        step(1, 99, 5, 1);
        check("clr_valid", int'(out_valid), 0);
        step(1, 5, 5, 0);
        check("clr_outp", int'(outp), 5);
        check("clr_full", int'(out_full), 0);

        // W=1 pairs
        for (int k = 1; k <= 4; k++) step(1, k * 3, 1, 0);
        check("w1_outp", int'(outp), 21);

        // async reset mid-stream
        step(1, 40, 4, 0);
        step(1, 41, 4, 0);
        #3 rst_n = 1'b0;
        #1;
        check("arst_outp", int'(outp), 0);
        check("arst_valid", int'(out_valid), 0);
        check("arst_full", int'(out_full), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 9, 4, 0);
        check("arst_9", int'(outp), 9);
        step(0, 0, 4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
